// File: rtl/int_priority_ctrl.sv
// Two-bank interrupt priority controller: edge/level capture into PEND, masked
// fixed-priority arbitration (bank 1 over bank 2, lowest index first), IDLE/ASSERT/SERVICE handshake.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | no vector presented; arbitrate eligible sources
//   S_ASSERT  | latched vector presented, IRQ high until ACK or source masked
//   S_SERVICE | source granted and in service (BUSY), waiting for EOI
module int_priority_ctrl #(
    parameter bit EDGE = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_req1,
    input  logic [7:0]  i_req2,
    input  logic        i_mask_we,
    input  logic [15:0] i_mask_in,
    input  logic        i_ack,
    input  logic        i_eoi,
    output logic        o_irq,
    output logic        o_int1,
    output logic        o_int2,
    output logic [2:0]  o_out,
    output logic [15:0] o_mask,
    output logic [15:0] o_pend,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_prev;
    logic [15:0] r_pend;
    logic [15:0] r_mask;
    logic [2:0]  r_out;
    logic        r_bank2;

    logic [15:0] w_req;
    logic [15:0] w_set;
    logic [15:0] w_clr;
    logic [15:0] w_elig;
    logic        w_any;
    logic        w_win_bank2;
    logic [2:0]  w_win_idx;
    logic [3:0]  w_src;
    logic        w_src_masked;

    // Scanning downward so the lowest set index is the last one written.
    function automatic logic [2:0] f_lowest(input logic [7:0] v);
        f_lowest = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) f_lowest = 3'(i);
        end
    endfunction

    assign w_req        = {i_req2, i_req1};
    assign w_set        = EDGE ? (w_req & ~r_prev) : w_req;
    assign w_elig       = r_pend & ~r_mask;
    assign w_any        = |w_elig;
    assign w_win_bank2  = ~|w_elig[7:0];
    assign w_win_idx    = f_lowest(w_win_bank2 ? w_elig[15:8] : w_elig[7:0]);
    assign w_src        = {r_bank2, r_out};
    assign w_src_masked = r_mask[w_src];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_prev  <= 16'h0000;
            r_pend  <= 16'h0000;
            r_mask  <= 16'h0000;
        end else begin
            r_state <= w_next;
            r_prev  <= w_req;
            // A set in the same cycle as a grant clear wins.
            r_pend  <= (r_pend & ~w_clr) | w_set;
            if (i_mask_we) r_mask <= i_mask_in;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out   <= 3'd0;
            r_bank2 <= 1'b0;
        end else if (r_state == S_IDLE && w_any) begin
            r_out   <= w_win_idx;
            r_bank2 <= w_win_bank2;
        end
    end

    always_comb begin
        w_next = r_state;
        w_clr  = 16'h0000;
        case (r_state)
            S_IDLE: begin
                if (w_any) w_next = S_ASSERT;
            end
            S_ASSERT: begin
                // Masking the presented source withdraws it, even against a same-cycle ACK.
                if (w_src_masked) begin
                    w_next = S_IDLE;
                end else if (i_ack) begin
                    w_next       = S_SERVICE;
                    w_clr[w_src] = 1'b1;
                end
            end
            S_SERVICE: begin
                if (i_eoi) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign o_irq  = (r_state == S_ASSERT) && !w_src_masked;
    assign o_busy = (r_state == S_SERVICE);
    assign o_int1 = (r_state != S_IDLE) && !r_bank2;
    assign o_int2 = (r_state != S_IDLE) && r_bank2;
    assign o_out  = r_out;
    assign o_mask = r_mask;
    assign o_pend = r_pend;

endmodule

// File: tb/tb_int_priority_ctrl.sv
// Directed-vector bench for int_priority_ctrl: an edge-capture instance for most
// scenarios and a level-capture instance for the re-pend scenario.
module tb_int_priority_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  req1, req2;
    logic        mask_we;
    logic [15:0] mask_in;
    logic        ack, eoi;

    logic        irq, int1, int2, busy;
    logic [2:0]  out;
    logic [15:0] mask, pend;

    logic        irq_l, int1_l, int2_l, busy_l;
    logic [2:0]  out_l;
    logic [15:0] mask_l, pend_l;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    int_priority_ctrl #(.EDGE(1'b1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_req1(req1), .i_req2(req2),
        .i_mask_we(mask_we), .i_mask_in(mask_in), .i_ack(ack), .i_eoi(eoi),
        .o_irq(irq), .o_int1(int1), .o_int2(int2), .o_out(out),
        .o_mask(mask), .o_pend(pend), .o_busy(busy)
    );

    int_priority_ctrl #(.EDGE(1'b0)) u_dut_lvl (
        .i_clk(clk), .i_rst(rst), .i_req1(req1), .i_req2(req2),
        .i_mask_we(mask_we), .i_mask_in(mask_in), .i_ack(ack), .i_eoi(eoi),
        .o_irq(irq_l), .o_int1(int1_l), .o_int2(int2_l), .o_out(out_l),
        .o_mask(mask_l), .o_pend(pend_l), .o_busy(busy_l)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        req1    = 8'h00;
        req2    = 8'h00;
        mask_we = 1'b0;
        mask_in = 16'h0000;
        ack     = 1'b0;
        eoi     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_irq",  16'(irq),  16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_out",  16'(out),  16'd0);
        chk("rst_pend", pend, 16'h0000);
        chk("rst_mask", mask, 16'h0000);

        // Scenario 1: bank-2 bit 4, two-clock latency
        req2 = 8'h10;
        tick();
        chk("s1_pend",  pend, 16'h1000);
        chk("s1_irq0",  16'(irq), 16'd0);
        tick();
        chk("s1_irq",   16'(irq),  16'd1);
        chk("s1_int2",  16'(int2), 16'd1);
        chk("s1_int1",  16'(int1), 16'd0);
        chk("s1_out",   16'(out),  16'd4);
        pulse_ack();
        chk("s1_busy",  16'(busy), 16'd1);
        chk("s1_irqsv", 16'(irq),  16'd0);
        chk("s1_pclr",  pend, 16'h0000);
        pulse_eoi();
        chk("s1_idle",  16'(busy), 16'd0);
        chk("s1_i2idl", 16'(int2), 16'd0);
        chk("s1_outh",  16'(out),  16'd4);

        // Scenario 2: bank 1 beats bank 2, lowest index first
        do_reset();
        req1 = 8'h0C;
        req2 = 8'h01;
        tick();
        chk("s2_pend",  pend, 16'h010C);
        tick();
        chk("s2_out1",  16'(out),  16'd2);
        chk("s2_int1",  16'(int1), 16'd1);
        pulse_ack();
        chk("s2_pend1", pend, 16'h0108);
        pulse_eoi();
        chk("s2_gap",   16'(irq),  16'd0);
        tick();
        chk("s2_out2",  16'(out),  16'd3);
        chk("s2_int1b", 16'(int1), 16'd1);
        pulse_ack();
        pulse_eoi();
        tick();
        chk("s2_out3",  16'(out),  16'd0);
        chk("s2_int2",  16'(int2), 16'd1);
        pulse_ack();
        chk("s2_pend3", pend, 16'h0000);
        pulse_eoi();

        // Scenario 3: bank 1 masked, bank 2 wins, masked bit stays pending
        do_reset();
        mask_we = 1'b1;
        mask_in = 16'h00FF;
        tick();
        mask_we = 1'b0;
        chk("s3_mask",  mask, 16'h00FF);
        req1 = 8'h80;
        req2 = 8'h80;
        tick();
        chk("s3_pend",  pend, 16'h8080);
        tick();
        chk("s3_out",   16'(out),  16'd7);
        chk("s3_int2",  16'(int2), 16'd1);
        chk("s3_int1",  16'(int1), 16'd0);
        pulse_ack();
        chk("s3_pkeep", pend, 16'h0080);
        pulse_eoi();
        tick();
        chk("s3_noirq", 16'(irq), 16'd0);

        // Scenario 4: mask the presented source during ASSERT
        do_reset();
        req1 = 8'h08;
        tick();
        tick();
        chk("s4_irq",   16'(irq), 16'd1);
        chk("s4_out",   16'(out), 16'd3);
        mask_we = 1'b1;
        mask_in = 16'h0008;
        tick();
        mask_we = 1'b0;
        chk("s4_irqdn", 16'(irq), 16'd0);
        tick();
        chk("s4_idle",  16'(int1), 16'd0);
        chk("s4_pend",  pend, 16'h0008);
        chk("s4_outh",  16'(out), 16'd3);
        mask_we = 1'b1;
        mask_in = 16'h0000;
        tick();
        mask_we = 1'b0;
        tick();
        chk("s4_reirq", 16'(irq), 16'd1);
        chk("s4_reout", 16'(out), 16'd3);

        // Scenario 5: level capture, stray ACK/EOI ignored
        do_reset();
        pulse_ack();
        chk("s5_ackid", 16'(irq_l),  16'd0);
        pulse_eoi();
        chk("s5_eoiid", 16'(busy_l), 16'd0);
        req1 = 8'h01;
        tick();
        chk("s5_pend",  pend_l, 16'h0001);
        tick();
        chk("s5_irq",   16'(irq_l), 16'd1);
        chk("s5_out",   16'(out_l), 16'd0);
        pulse_eoi();
        chk("s5_eoias", 16'(irq_l), 16'd1);
        pulse_ack();
        chk("s5_busy",  16'(busy_l), 16'd1);
        chk("s5_repnd", pend_l, 16'h0001);
        pulse_ack();
        chk("s5_acksv", 16'(busy_l), 16'd1);
        pulse_eoi();
        chk("s5_idle",  16'(irq_l), 16'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("s5_regnt", 16'(irq_l),  16'd1);
        chk("s5_nosv",  16'(busy_l), 16'd0);
        chk("s5_int1",  16'(int1_l), 16'd1);

        // Scenario 6: async reset during SERVICE, request held across release
        do_reset();
        req2 = 8'h20;
        tick();
        tick();
        chk("s6_out",   16'(out), 16'd5);
        pulse_ack();
        chk("s6_busy",  16'(busy), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("s6_rirq",  16'(irq),  16'd0);
        chk("s6_rbusy", 16'(busy), 16'd0);
        chk("s6_rpend", pend, 16'h0000);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("s6_pend",  pend, 16'h2000);
        tick();
        chk("s6_irq",   16'(irq),  16'd1);
        chk("s6_out2",  16'(out),  16'd5);
        chk("s6_int2",  16'(int2), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
